// File: rtl/mem_bus_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
// State encoding, requester IDs and transfer size codes.
package mem_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      I_ADDR,
      I_DATA,
      D_ADDR,
      D_DATA
   } state_t;

   localparam logic REQ_INST = 1'b0;
   localparam logic REQ_DATA = 1'b1;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// arb_pick: chooses which requester wins the bus when idle.
// ARB_ROUND_ROBIN_EN alternates winners on a tie; otherwise data wins.
module arb_pick
   import mem_bus_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic last_grant,
   output logic grant
);

   // With nobody asking, the output just echoes the previous winner.
   always_comb begin
      grant = last_grant;
`ifdef ARB_ROUND_ROBIN_EN
      if (i_req && d_req)
         grant = (last_grant == REQ_DATA) ? REQ_INST : REQ_DATA;
      else if (d_req)
         grant = REQ_DATA;
      else if (i_req)
         grant = REQ_INST;
`else
      if (d_req)
         grant = REQ_DATA;
      else if (i_req)
         grant = REQ_INST;
`endif
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (inst/data) to one-slave memory bus arbiter, one transaction
// in flight. Optional macro ARB_ROUND_ROBIN_EN selects alternating priority.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   input  logic          i_uncached,
   output logic          i_addr_ok,
   output logic          i_data_ok,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_wr,
   input  logic [1:0]    d_size,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic          d_uncached,
   output logic          d_addr_ok,
   output logic          d_data_ok,
   output logic [DW-1:0] d_rdata,
   output logic          m_req,
   output logic          m_wr,
   output logic [1:0]    m_size,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   output logic          m_uncached,
   input  logic          m_addr_ok,
   input  logic          m_data_ok,
   input  logic [DW-1:0] m_rdata
);

   state_t state, state_nx;

   logic          lat_wr;
   logic [1:0]    lat_size;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;
   logic          lat_unc;

   logic last_grant;
   logic grant;
   logic take;

   assign take = resetn && (state == IDLE) && (i_req || d_req);

   arb_pick u_pick (
      .i_req      (i_req),
      .d_req      (d_req),
      .last_grant (last_grant),
      .grant      (grant)
   );

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q;

   always_ff @(posedge clk) begin
      if (!resetn)
         last_q <= REQ_INST;
      else if (take)
         last_q <= grant;
   end

   assign last_grant = last_q;
`else
   assign last_grant = REQ_INST;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         lat_wr    <= 1'b0;
         lat_size  <= 2'd0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_unc   <= 1'b0;
      end else begin
         state <= state_nx;
         if (take) begin
            if (grant == REQ_DATA) begin
               lat_wr    <= d_wr;
               lat_size  <= d_size;
               lat_addr  <= d_addr;
               lat_wdata <= d_wdata;
               lat_unc   <= d_uncached;
            end else begin
               lat_wr    <= 1'b0;
               lat_size  <= SZ_WORD;
               lat_addr  <= i_addr;
               lat_wdata <= '0;
               lat_unc   <= i_uncached;
            end
         end
      end
   end

   // Everything is gated by resetn so a reset cycle shows a quiet bus.
   always_comb begin
      state_nx   = state;
      i_addr_ok  = 1'b0;
      i_data_ok  = 1'b0;
      i_rdata    = '0;
      d_addr_ok  = 1'b0;
      d_data_ok  = 1'b0;
      d_rdata    = '0;
      m_req      = 1'b0;
      m_wr       = 1'b0;
      m_size     = 2'd0;
      m_addr     = '0;
      m_wdata    = '0;
      m_uncached = 1'b0;
      if (resetn) begin
         unique case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  if (grant == REQ_DATA) begin
                     d_addr_ok = 1'b1;
                     state_nx  = D_ADDR;
                  end else begin
                     i_addr_ok = 1'b1;
                     state_nx  = I_ADDR;
                  end
               end
            end
            I_ADDR, D_ADDR: begin
               m_req      = 1'b1;
               m_wr       = lat_wr;
               m_size     = lat_size;
               m_addr     = lat_addr;
               m_wdata    = lat_wdata;
               m_uncached = lat_unc;
               if (m_addr_ok)
                  state_nx = (state == I_ADDR) ? I_DATA : D_DATA;
            end
            I_DATA: begin
               if (m_data_ok) begin
                  i_data_ok = 1'b1;
                  i_rdata   = m_rdata;
                  state_nx  = IDLE;
               end
            end
            D_DATA: begin
               if (m_data_ok) begin
                  d_data_ok = 1'b1;
                  d_rdata   = lat_wr ? '0 : m_rdata;
                  state_nx  = IDLE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- AW, 32, physical address width
- DW, 32, data width
REQ-002 SHALL have these ports (name direction width meaning):
- clk  in  1  single clock
- resetn  in  1  reset, synchronous, active-low
- i_req  in  1  instruction request
- i_addr  in  AW  instruction physical address
- i_uncached  in  1  instruction uncached attribute
- i_addr_ok  out  1  instruction request accepted
- i_data_ok  out  1  instruction read data valid
- i_rdata  out  DW  instruction read data
- d_req  in  1  data request
- d_wr  in  1  data write (1) or read (0)
- d_size  in  2  0=byte, 1=half, 2=word
- d_addr  in  AW  data physical address
- d_wdata  in  DW  data write data
- d_uncached  in  1  data uncached attribute (kseg1)
- d_addr_ok  out  1  data request accepted
- d_data_ok  out  1  data read data valid or write complete
- d_rdata  out  DW  data read data
- m_req, m_wr, m_size, m_addr, m_wdata, m_uncached  out  1/1/2/AW/DW/1  downstream request
- m_addr_ok  in  1  downstream accepted the request
- m_data_ok  in  1  downstream response
- m_rdata  in  DW  downstream read data

Function
REQ-003 SHALL run a state machine with states IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA.
REQ-004 In IDLE with any request pending: SHALL pick one requester, latch its request fields into internal registers, pulse that requester's *_addr_ok combinationally in the same cycle, and go to x_ADDR.
REQ-005 Without ARB_ROUND_ROBIN_EN: when both request at once, SHALL grant data.
REQ-006 For an instruction grant: SHALL drive m_wr=0 and m_size=2.
REQ-007 In x_ADDR: SHALL drive m_req=1 with the latched fields; on m_addr_ok SHALL go to x_DATA.
REQ-008 In x_DATA: SHALL drive m_req=0; on m_data_ok SHALL pulse the granted *_data_ok for exactly 1 cycle with *_rdata=m_rdata, then go to IDLE.
REQ-009 Latency: minimum 3 cycles from IDLE grant to *_data_ok (grant, addr, data); no new grant in the cycle *_data_ok is pulsed.
REQ-010 m_data_ok in IDLE or x_ADDR SHALL be ignored; m_addr_ok outside x_ADDR SHALL be ignored.
REQ-011 At most one outstanding downstream transaction SHALL exist.
REQ-012 The non-granted requester's *_addr_ok and *_data_ok SHALL stay 0.
REQ-013 Requesters hold *_req and fields until *_addr_ok; a *_req dropped before its grant SHALL be ignored.
REQ-014 *_rdata SHALL be 0 whenever the matching *_data_ok is 0.

Reset
REQ-015 On resetn=0 at a clk edge: state=IDLE, latched fields=0, all outputs=0.
REQ-016 Reset mid-transaction SHALL abandon the transaction without a *_data_ok pulse.

Configuration
REQ-017 ARB_ROUND_ROBIN_EN defined: on a simultaneous request, SHALL grant the requester not granted last; a 1-bit last-grant register resets to "inst", so data wins the first tie.
REQ-018 ARB_ROUND_ROBIN_EN undefined: fixed data priority per REQ-005; no last-grant register.

Structure
REQ-019 Shared package mem_bus_pkg SHALL hold the state enum, requester IDs (REQ_INST=0, REQ_DATA=1) and size codes (SZ_BYTE/SZ_HALF/SZ_WORD).
REQ-020 Priority selection SHALL be one sub-module arb_pick (inputs i_req, d_req, last grant; output grant ID).

Verification
REQ-021 Single read: d_req, d_addr=0x1FC00010, d_uncached=1; m_addr_ok after 1 cycle, m_data_ok after 2 more cycles with m_rdata=0xDEADBEEF -> d_addr_ok in cycle 0, m_addr=0x1FC00010, m_uncached=1, then d_data_ok for 1 cycle with d_rdata=0xDEADBEEF.
REQ-022 Simultaneous i_req and d_req, fixed priority -> data served first, then instruction; i_addr_ok only after d_data_ok.
REQ-023 Same stimulus as REQ-022 repeated 4 times with ARB_ROUND_ROBIN_EN -> grant order D, I, D, I.
REQ-024 Write: d_wr=1, d_size=0, d_wdata=0x000000A5 -> m_wr=1, m_size=0, m_wdata=0x000000A5; d_data_ok on m_data_ok; d_rdata=0.
REQ-025 Stray m_data_ok in IDLE -> no *_data_ok; resetn=0 during D_DATA -> IDLE next cycle, all outputs 0, no d_data_ok pulse.
